// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel FIFO slice.
//   - align_state_e : alignment states of the drain side
//   - PIXEL_W_DEF   : default colour depth (bits per pixel)
//   - BLACK         : colour shown whenever no valid pixel is being output
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int PIXEL_W_DEF = 3;

    localparam logic [PIXEL_W_DEF-1:0] BLACK = '0;

    // SYNC   : hunting for a start-of-frame entry, discarding everything else
    // ARMED  : start-of-frame entry at the head, waiting for the display's frame start
    // STREAM : popping one pixel per active-display cycle
    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } align_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data and an explicit
// entry count.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push_i        : write wdata_i this cycle (ignored when full)
//   pop_i         : drop the head entry this cycle (ignored when empty)
//   wdata_i       : entry to write
//   rdata_o       : current head entry (valid when !empty_o)
//   full_o        : level_o == DEPTH
//   empty_o       : level_o == 0
//   level_o       : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [ADDR_W:0]   level_q;
    logic              doPush;
    logic              doPop;

    // Full is decided from the current count only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign full_o  = (level_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem[rdPtr_q];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; the count carries
    // one extra bit so that full and empty stay distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + ADDR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + ADDR_W'(1);
            end
            if (doPush && !doPop) begin
                level_q <= level_q + (ADDR_W+1)'(1);
            end else if (doPop && !doPush) begin
                level_q <= level_q - (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// vga_pixel_fifo
// Frame-aligned pixel FIFO between the pattern/mixer producer and the VGA
// display stage. Entries are {sof, pixel}. The drain side discards data until
// a start-of-frame entry is at the head, waits for the display's frame start,
// then pops one pixel per active-display cycle. Underflow and sof/frame_start
// disagreement are flagged (sticky) and trigger a re-lock.
// Ports:
//   clk, rst          : pixel clock, asynchronous active-high reset
//   in_pixel, in_sof  : producer pixel and its start-of-frame tag
//   in_valid/in_ready : producer handshake (in_ready = FIFO not full)
//   disp_en           : active-display flag from the timing generator
//   frame_start       : first active pixel of a frame (only honoured with disp_en)
//   pixel             : registered colour for the display stage
//   underflow         : sticky, drain found the FIFO empty while streaming
//   misalign          : sticky, sof position disagreed with frame_start
//   err_clr           : clears both sticky flags (a new error in the same cycle wins)
//   level             : current FIFO entry count
// ---------------------------------------------------------------------------
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int PIXEL_W = PIXEL_W_DEF,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_sof,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               disp_en,
    input  logic               frame_start,
    output logic [PIXEL_W-1:0] pixel,
    output logic               underflow,
    output logic               misalign,
    input  logic               err_clr,
    output logic [ADDR_W:0]    level
);

    align_state_e        state_q;
    align_state_e        state_d;
    logic [PIXEL_W-1:0]  pixel_q;
    logic [PIXEL_W-1:0]  pixel_d;
    logic                underflow_q;
    logic                misalign_q;
    logic                ufSet;
    logic                misSet;
    logic                pop;
    logic                full;
    logic                empty;
    logic [PIXEL_W:0]    head;
    logic                headSof;
    logic [PIXEL_W-1:0]  headPixel;
    logic                frameGo;

    sync_fifo #(
        .WIDTH  (PIXEL_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop),
        .wdata_i ({in_sof, in_pixel}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign in_ready  = !full;
    assign headSof   = head[PIXEL_W];
    assign headPixel = head[PIXEL_W-1:0];
    assign frameGo   = frame_start && disp_en;

    assign pixel     = pixel_q;
    assign underflow = underflow_q;
    assign misalign  = misalign_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: lock onto an sof entry, start streaming on the
    // display's frame start, and fall back on any disagreement or underflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: begin
                if (!empty && headSof) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (frameGo && !empty) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (disp_en) begin
                    if (empty) begin
                        state_d = SYNC;
                    end else if (frame_start && !headSof) begin
                        state_d = SYNC;
                    end else if (!frame_start && headSof) begin
                        state_d = ARMED;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Output logic: pops, next colour and error events. While streaming,
    // an entry is consumed only when its sof tag agrees with frame_start.
    always_comb begin
        pop     = 1'b0;
        pixel_d = PIXEL_W'(BLACK);
        ufSet   = 1'b0;
        misSet  = 1'b0;
        case (state_q)
            SYNC: begin
                pop = !empty && !headSof;
            end
            ARMED: begin
                if (frameGo && !empty) begin
                    pop     = 1'b1;
                    pixel_d = headPixel;
                end
            end
            STREAM: begin
                if (disp_en) begin
                    if (empty) begin
                        ufSet = 1'b1;
                    end else if (frame_start == headSof) begin
                        pop     = 1'b1;
                        pixel_d = headPixel;
                    end else begin
                        misSet = 1'b1;
                    end
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Output colour register and sticky error flags; a set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q     <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pixel_q     <= pixel_d;
            underflow_q <= ufSet  || (underflow_q && !err_clr);
            misalign_q  <= misSet || (misalign_q && !err_clr);
        end
    end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_fifo
// Self-checking bench for vga_pixel_fifo: directed frame scenarios followed by
// randomised traffic, all compared every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_vga_pixel_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_pixel = '0;
    logic       in_sof = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       disp_en = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] pixel;
    logic       underflow;
    logic       misalign;
    logic       err_clr = 1'b0;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    // Behavioural model: a queue of {sof, pixel} entries plus the drain mode.
    typedef enum {M_SYNC, M_ARMED, M_STREAM} mode_e;
    logic [3:0] mq[$];
    mode_e      mMode;
    int         mPixel;
    bit         mUnderflow;
    bit         mMisalign;

    vga_pixel_fifo #(
        .PIXEL_W (3),
        .DEPTH   (DEPTH),
        .ADDR_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_pixel    (in_pixel),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .disp_en     (disp_en),
        .frame_start (frame_start),
        .pixel       (pixel),
        .underflow   (underflow),
        .misalign    (misalign),
        .err_clr     (err_clr),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mMode      = M_SYNC;
        mPixel     = 0;
        mUnderflow = 1'b0;
        mMisalign  = 1'b0;
    endtask

    // One pixel-clock step of the model, using the inputs held across the edge.
    task automatic modelStep();
        bit doPop;
        bit ufEv;
        bit misEv;
        bit acceptPush;
        bit isEmpty;
        bit hSof;
        int hPix;
        int nextPix;
        doPop      = 1'b0;
        ufEv       = 1'b0;
        misEv      = 1'b0;
        nextPix    = 0;
        acceptPush = in_valid && (mq.size() != DEPTH);
        isEmpty    = (mq.size() == 0);
        hSof       = 1'b0;
        hPix       = 0;
        if (!isEmpty) begin
            hSof = mq[0][3];
            hPix = int'(mq[0][2:0]);
        end
        if (mMode == M_SYNC) begin
            if (!isEmpty && hSof) mMode = M_ARMED;
            else if (!isEmpty)    doPop = 1'b1;
        end else if (mMode == M_ARMED) begin
            if (disp_en && frame_start && !isEmpty) begin
                doPop   = 1'b1;
                nextPix = hPix;
                mMode   = M_STREAM;
            end
        end else if (disp_en) begin
            if (isEmpty) begin
                ufEv  = 1'b1;
                mMode = M_SYNC;
            end else if (frame_start && hSof) begin
                doPop   = 1'b1;
                nextPix = hPix;
            end else if (frame_start && !hSof) begin
                misEv = 1'b1;
                mMode = M_SYNC;
            end else if (!frame_start && hSof) begin
                misEv = 1'b1;
                mMode = M_ARMED;
            end else begin
                doPop   = 1'b1;
                nextPix = hPix;
            end
        end
        if (doPop) void'(mq.pop_front());
        if (acceptPush) mq.push_back({in_sof, in_pixel});
        mPixel     = nextPix;
        mUnderflow = ufEv || (mUnderflow && !err_clr);
        mMisalign  = misEv || (mMisalign && !err_clr);
    endtask

    // Drive one cycle of inputs, advance through the clock edge, step the model.
    task automatic applyStimulus(input bit v, input bit s, input logic [2:0] p,
                                 input bit de, input bit fs, input bit clr);
        in_valid    = v;
        in_sof      = s;
        in_pixel    = p;
        disp_en     = de;
        frame_start = fs;
        err_clr     = clr;
        @(posedge clk);
        if (!rst) modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomTraffic(input int n);
        bit de;
        for (int i = 0; i < n; i++) begin
            de = ($urandom_range(0, 9) < 7);
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                          3'($urandom_range(0, 7)), de,
                          de && ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
        end
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("pixel", int'(pixel), mPixel);
            checkOutput("underflow", int'(underflow), int'(mUnderflow));
            checkOutput("misalign", int'(misalign), int'(mMisalign));
            checkOutput("level", int'(level), mq.size());
            checkOutput("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
        end
    end

    initial begin
        int expS2[8];
        int idx;
        modelReset();
        checkOn = 1'b1;
        idle(2);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_ready", int'(in_ready), 1);
        rst = 1'b0;
        idle(2);

        // Normal frame: values 1..7,0 with sof on the first.
        $display("[TB] normal frame");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 0), 3'(i + 1), 1'b0, 1'b0, 1'b0);
        idle(1);
        expS2 = '{1, 2, 3, 4, 5, 6, 7, 0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, (i == 0), 1'b0);
            checkOutput("s2_pixel", int'(pixel), expS2[i]);
        end
        idle(1);
        checkOutput("s2_level", int'(level), 0);
        checkOutput("s2_pixel_idle", int'(pixel), 0);
        checkOutput("s2_flags", int'({underflow, misalign}), 0);

        // Underflow: a 3-pixel frame drained for 5 cycles.
        $display("[TB] underflow");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, (i == 0), 3'(i + 5), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, (i == 0), 1'b0);
            if (i == 0) checkOutput("s3_px0", int'(pixel), 5);
            if (i == 3) checkOutput("s3_uf_cycle4", int'(underflow), 1);
            if (i == 3) checkOutput("s3_pixel_uf", int'(pixel), 0);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("s3_uf_cleared", int'(underflow), 0);

        // Resync: garbage without sof, then a proper 4-pixel frame.
        $display("[TB] resync");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 3'(i + 2), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), 3'(7 - i), 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("s4_level", int'(level), 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, (i == 0), 1'b0);
            checkOutput("s4_pixel", int'(pixel), 7 - i);
        end
        checkOutput("s4_misalign", int'(misalign), 0);
        idle(1);

        // Backpressure: fill, hold a 17th push, pop one, then drain all.
        $display("[TB] backpressure");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, (i == 0), 3'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("s5_level_full", int'(level), DEPTH);
        checkOutput("s5_ready_full", int'(in_ready), 0);
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_level_held", int'(level), DEPTH);
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("s5_ready_after_pop", int'(in_ready), 1);
        checkOutput("s5_level_after_pop", int'(level), DEPTH - 1);
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_level_refill", int'(level), DEPTH);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("s5_last_pixel", int'(pixel), 5);
        checkOutput("s5_level_drained", int'(level), 0);
        idle(1);

        // Misalign: producer frame 2 pixels shorter than the display frame.
        $display("[TB] misalign");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), 3'(i + 1), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, (i == 0), 3'(6 - i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, (i == 0), 1'b0);
            if (i == 4) checkOutput("s6_misalign", int'(misalign), 1);
            if (i == 4) checkOutput("s6_pixel_black", int'(pixel), 0);
        end
        idle(2);
        checkOutput("s6_level_armed", int'(level), 6);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, (i == 0), 1'b0);
            checkOutput("s6_realigned", int'(pixel), 6 - i);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("s6_cleared", int'(misalign), 0);

        $display("[TB] random traffic");
        randomTraffic(1500);

        // Reset in the middle of a stream.
        $display("[TB] mid-stream reset");
        idx = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, (i == 0), 3'(i + 2), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        modelReset();
        idle(2);
        checkOutput("s1_level", int'(level), 0);
        checkOutput("s1_ready", int'(in_ready), 1);
        checkOutput("s1_pixel", int'(pixel), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, (i == 0), 3'(i + 3), 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("s1_first_after_reset", int'(pixel), 3);
        idx++;

        randomTraffic(1000);
        idle(2);
        checkOn = 1'b0;
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
